// File: rtl/dti_serialize_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dti_pkg
//  Description : Shared helpers for the DTI width converters (serialize and
//                the matching pack block). Hosts the eot flag position helper
//                and a counter sizing helper that never returns zero.
//  Revision    : 1.0 - initial release
// ============================================================================
package dti_pkg;

  // Position of the end-of-transfer flag above an element of the given width.
  function automatic int eot_bit(input int width);
    return width;
  endfunction

  // Counter width for an index over n items; at least one bit so that the
  // single-element case still has a legal vector.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dti_serialize_if.sv
`default_nettype none
// ============================================================================
//  Interface   : dti
//  Description : DTI valid/ready stream bundle.
//                  valid - producer has data this cycle
//                  ready - consumer can take data this cycle
//                  data  - payload, W bits
//                A transfer happens on a rising edge where valid & ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dti #(
  parameter int W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/dti_serialize.sv
`default_nettype none
// ============================================================================
//  Module      : dti_serialize
//  Description : Width down-converter on DTI. Captures one DIN*NUM-bit word and
//                emits its NUM elements (element 0 first, from the LSBs) as
//                DIN-bit elements with an eot flag on the last one. Output is
//                fully registered; back-to-back words stream with no bubble.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                din  - consumer side, DIN*NUM-bit packed words
//                dout - producer side, {eot, element} (DIN+1 bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module dti_serialize
  import dti_pkg::*;
#(
  parameter int DIN = 16,
  parameter int NUM = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  dti.consumer      din,
  dti.producer      dout
);

  localparam int            CW     = clog2_min1(NUM);
  localparam int            C_EOT  = eot_bit(DIN);
  localparam logic [CW-1:0] C_LAST = CW'(NUM - 1);

  logic [DIN*NUM-1:0] r_hold;
  logic               r_full;
  logic [CW-1:0]      r_idx;

  logic               w_last;
  logic               w_accept;
  logic               w_out_hs;
  logic [DIN-1:0]     w_elem;

  // With NUM == 1 the index never moves, so last is permanently true and
  // the block behaves as a plain pipeline register.
  assign w_last   = (r_idx == C_LAST);

  // Ready depends only on our state and the downstream ready, never on
  // din.valid, so no valid->valid combinational path exists.
  assign din.ready = ~rst & (~r_full | (dout.ready & w_last));

  assign w_accept = din.valid & din.ready;
  assign w_out_hs = r_full & dout.ready;

  // Element select as a compare-mux so the index arithmetic stays in range.
  always_comb begin
    w_elem = '0;
    for (int i = 0; i < NUM; i++) begin
      if (r_idx == CW'(i)) begin
        w_elem = r_hold[i*DIN +: DIN];
      end
    end
  end

  assign dout.valid        = r_full;
  assign dout.data[C_EOT]  = w_last;
  assign dout.data[DIN-1:0] = w_elem;

  // Control state. An accept takes priority: it covers both the idle load and
  // the reload that happens on the last-element handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_idx  <= '0;
    end else if (w_out_hs) begin
      if (w_last) begin
        r_full <= 1'b0;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + CW'(1);
      end
    end
  end

  // Data holding register needs no reset; it is only observed while r_full.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= din.data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dti_serialize.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dti_serialize
//  Description : Self-checking bench for dti_serialize. DUT A uses DIN=8,
//                NUM=4; DUT B uses DIN=8, NUM=1. Directed scenarios plus a
//                randomized valid/ready run against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dti_serialize;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dti #(.W(32)) a_in  ();
  dti #(.W(9))  a_out ();
  dti #(.W(8))  b_in  ();
  dti #(.W(9))  b_out ();

  dti_serialize #(.DIN(8), .NUM(4)) u_dut_a (
    .clk  (clk),
    .rst  (rst),
    .din  (a_in),
    .dout (a_out)
  );

  dti_serialize #(.DIN(8), .NUM(1)) u_dut_b (
    .clk  (clk),
    .rst  (rst),
    .din  (b_in),
    .dout (b_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Drive all inputs after the falling edge, then settle 1 time unit so the
  // combinational ready and registered outputs can be sampled mid-cycle.
  task automatic step(input logic r, input logic dv, input logic [31:0] dd,
                      input logic rd, input logic dv1 = 1'b0,
                      input logic [7:0] dd1 = 8'h00, input logic rd1 = 1'b0);
    @(negedge clk);
    rst         = r;
    a_in.valid  = dv;
    a_in.data   = dd;
    a_out.ready = rd;
    b_in.valid  = dv1;
    b_in.data   = dd1;
    b_out.ready = rd1;
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (a_out.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a_out.valid);
    else n_pass++;
    n_checks++;
    if (a_in.ready !== 1'b0) $display("FAIL reset_ready_in_rst: got %b want 0", a_in.ready);
    else n_pass++;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (a_out.valid !== 1'b0 || a_in.ready !== 1'b1)
      $display("FAIL reset_release: got valid=%b ready=%b want 0/1", a_out.valid, a_in.ready);
    else n_pass++;
    n_checks++;
    if (b_out.valid !== 1'b0 || b_in.ready !== 1'b1)
      $display("FAIL reset_release_num1: got valid=%b ready=%b want 0/1", b_out.valid, b_in.ready);
    else n_pass++;
  endtask

  task automatic test_single_word();
    logic [8:0] exp [4] = '{9'h011, 9'h022, 9'h033, 9'h144};
    step(1'b0, 1'b1, 32'h44332211, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (a_out.valid !== 1'b1 || a_out.data !== exp[k])
        $display("FAIL single_elem%0d: got v=%b d=%h want v=1 d=%h", k, a_out.valid, a_out.data, exp[k]);
      else n_pass++;
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (a_out.valid !== 1'b0) $display("FAIL single_idle: got valid=%b want 0", a_out.valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp [8] = '{9'h011, 9'h022, 9'h033, 9'h144,
                            9'h055, 9'h066, 9'h077, 9'h188};
    step(1'b0, 1'b1, 32'h44332211, 1'b1);
    n_checks++;
    if (a_in.ready !== 1'b1) $display("FAIL b2b_ready_accept: got %b want 1", a_in.ready);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, (k < 4), 32'h88776655, 1'b1);
      n_checks++;
      if (a_out.valid !== 1'b1 || a_out.data !== exp[k])
        $display("FAIL b2b_elem%0d: got v=%b d=%h want v=1 d=%h", k, a_out.valid, a_out.data, exp[k]);
      else n_pass++;
      n_checks++;
      if (a_in.ready !== ((k % 4) == 3))
        $display("FAIL b2b_ready%0d: got %b want %b", k, a_in.ready, ((k % 4) == 3));
      else n_pass++;
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (a_out.valid !== 1'b0) $display("FAIL b2b_idle: got valid=%b want 0", a_out.valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [8:0] exp [7] = '{9'h011, 9'h022, 9'h022, 9'h022, 9'h022, 9'h033, 9'h144};
    logic       rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    step(1'b0, 1'b1, 32'h44332211, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b0, 32'h0, rdy[k]);
      n_checks++;
      if (a_out.valid !== 1'b1 || a_out.data !== exp[k])
        $display("FAIL bp_cycle%0d: got v=%b d=%h want v=1 d=%h", k, a_out.valid, a_out.data, exp[k]);
      else n_pass++;
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (a_out.valid !== 1'b0) $display("FAIL bp_idle: got valid=%b want 0", a_out.valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    logic [8:0] exp [4] = '{9'h0AA, 9'h0BB, 9'h0CC, 9'h1DD};
    step(1'b0, 1'b1, 32'h44332211, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (a_out.data !== 9'h022) $display("FAIL rmw_pre: got %h want 022", a_out.data);
    else n_pass++;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (a_in.ready !== 1'b0) $display("FAIL rmw_ready_in_rst: got %b want 0", a_in.ready);
    else n_pass++;
    step(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1);
    n_checks++;
    if (a_out.valid !== 1'b0 || a_in.ready !== 1'b1)
      $display("FAIL rmw_after: got valid=%b ready=%b want 0/1", a_out.valid, a_in.ready);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (a_out.valid !== 1'b1 || a_out.data !== exp[k])
        $display("FAIL rmw_elem%0d: got v=%b d=%h want v=1 d=%h", k, a_out.valid, a_out.data, exp[k]);
      else n_pass++;
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  // Model: a queue of {eot, element} items still owed by the DUT. The DUT
  // is busy exactly while the queue is non-empty, and it is on its last
  // element exactly when one item remains.
  task automatic test_random();
    logic [8:0]  q [$];
    logic        dv, rd, exp_valid, exp_ready;
    logic [31:0] dd;
    logic [8:0]  want;
    for (int c = 0; c < 10000 + 8; c++) begin
      dv = (c < 10000) ? ($urandom_range(0, 99) < 60) : 1'b0;
      rd = (c < 10000) ? ($urandom_range(0, 99) < 60) : 1'b1;
      dd = $urandom;
      step(1'b0, dv, dd, rd);
      exp_valid = (q.size() != 0);
      exp_ready = (q.size() == 0) || (rd && q.size() == 1);
      n_checks++;
      if (a_out.valid !== exp_valid)
        $display("FAIL rand_valid c%0d: got %b want %b", c, a_out.valid, exp_valid);
      else n_pass++;
      n_checks++;
      if (a_in.ready !== exp_ready)
        $display("FAIL rand_ready c%0d: got %b want %b", c, a_in.ready, exp_ready);
      else n_pass++;
      if (exp_valid && rd) begin
        want = q.pop_front();
        n_checks++;
        if (a_out.data !== want)
          $display("FAIL rand_data c%0d: got %h want %h", c, a_out.data, want);
        else n_pass++;
      end
      if (dv && exp_ready) begin
        for (int e = 0; e < 4; e++) q.push_back({(e == 3), dd[e*8 +: 8]});
      end
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL rand_drain: got %0d pending want 0", q.size());
    else n_pass++;
  endtask

  task automatic test_num1();
    for (int k = 0; k <= 16; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, (k < 16), 8'(k + 1), 1'b1);
      n_checks++;
      if (b_in.ready !== 1'b1) $display("FAIL num1_ready%0d: got %b want 1", k, b_in.ready);
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (b_out.valid !== 1'b1 || b_out.data !== {1'b1, 8'(k)})
          $display("FAIL num1_elem%0d: got v=%b d=%h want v=1 d=%h", k, b_out.valid, b_out.data, {1'b1, 8'(k)});
        else n_pass++;
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (b_out.valid !== 1'b0) $display("FAIL num1_idle: got valid=%b want 0", b_out.valid);
    else n_pass++;
  endtask

  initial begin
    a_in.valid  = 1'b0;
    a_in.data   = '0;
    a_out.ready = 1'b0;
    b_in.valid  = 1'b0;
    b_in.data   = '0;
    b_out.ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    test_num1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dti_serialize.md
Name: dti_serialize

Overview:
- Width down-converter on the DTI valid/ready protocol. Unpacks one wide word of NUM elements into NUM sequential DIN-bit elements.
- Each output element carries an end-of-transfer (eot) flag, set on the last element of the word.
- Sits on the read side of wide buffers, e.g. after a FIFO holding packed words, and feeds narrow datapath consumers.
- Fully registered output, no bubbles between words under continuous flow.

Parameters:
- DIN, 16, element width in bits.
- NUM, 4, elements per input word (≥1). Input width is DIN*NUM.
- Local constant CW = max(1, $clog2(NUM)), the index counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- din  dti.consumer  DIN*NUM  packed input word. Element 0 is in the LSBs.
- dout  dti.producer  DIN+1  data[DIN-1:0] is the element; data[DIN] is eot.

Behaviour:
- State registers:
  - hold[DIN*NUM-1:0]: captured word.
  - full: hold contains unsent elements.
  - idx[CW-1:0]: index of the current element.
- last = (idx == NUM-1).
- Reset (rst high at posedge):
  - full <= 0, idx <= 0. hold is not reset.
  - dout.valid = 0 during and after reset until a word is accepted.
- din.ready:
  - Forced to 0 while rst is high.
  - Otherwise din.ready = ~full | (dout.ready & last). Purely combinational, no dependency on din.valid.
- Input accept (din.valid & din.ready): hold <= din.data, full <= 1, idx <= 0.
- Latency: a word accepted at edge t gives element 0 with dout.valid=1 in the cycle after edge t. Output is registered; there is no comb path din.data -> dout.data.
- dout.valid = full.
- dout.data = {last, hold[idx*DIN +: DIN]}.
- Output handshake (dout.valid & dout.ready):
  - If ~last: idx <= idx+1.
  - If last and din.valid: reload (the accept rule above), giving back-to-back words.
  - If last and ~din.valid: full <= 0, idx <= 0.
- Backpressure: while dout.valid & ~dout.ready, dout.data and dout.valid stay stable and idx is unchanged.
- Throughput: exactly NUM cycles per word at full flow; zero idle cycles between words.
- NUM=1:
  - idx is constant 0, eot is always 1.
  - The block degenerates to a single pipeline register with 100% throughput (ready = ~full | dout.ready).
- Reset mid-word: remaining elements are discarded. The next cycle has dout.valid=0 and din.ready=1. No partial word is resumed.
- No combinational loop: dout.ready -> din.ready is allowed; din.valid -> dout.valid is not.

Decomposition:
- Shared package dti_pkg holds:
  - function eot_bit(width), returning the position of the MSB flag;
  - the helper clog2_min1 for counter sizing. Both are reused by a future packing block (the inverse direction).
- No sub-module. The counter, hold register and handshake are small enough for one flat module of about 150 lines.

Test Plan (DIN=8, NUM=4 unless noted):
- Single word: din 0x44332211 for one cycle, dout.ready=1 → dout 0x011, 0x022, 0x033, 0x144 on four consecutive cycles starting one cycle after accept. Then dout.valid=0.
- Back-to-back: words 0x44332211 and 0x88776655 held valid, dout.ready=1 → 8 consecutive valid outputs with no gap. din.ready is high only in the accept cycle and on the last-element cycle.
- Backpressure: dout.ready low for 3 cycles while 0x022 is presented → 0x022 held stable. idx does not advance. The sequence resumes with 0x033 after ready returns.
- Reset mid-word: rst pulsed after 0x022 is transferred → next cycle dout.valid=0, din.ready=1. A new word 0xDDCCBBAA then yields 0x0AA, 0x0BB, 0x0CC, 0x1DD.
- Random valid/ready (10k cycles) against a scoreboard → output equals the unpacked input order, eot on every 4th element, and no valid drop without a handshake.
- NUM=1, DIN=8: stream 0x01..0x10 with dout.ready=1 → output 0x101..0x110, one per cycle, latency 1.
